// File: rtl/flux_pkg.sv
// Shared types, constants and helpers for the flux acquisition sequencer.
// Build option MFM_CRC_EN enables the running CRC in flux_acq_sequencer.
package flux_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_INDEX,
      HUNT,
      CAPTURE,
      DONE
   } seq_state_e;

   localparam logic [15:0] MFM_SYNC_A1    = 16'h4489;
   localparam logic [7:0]  MFM_SYNC_BYTE  = 8'hA1;
   localparam logic [15:0] CRC_CCITT_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT       = 16'hFFFF;

   // One byte of CRC-16/CCITT, MSB first.
   function automatic logic [15:0] crc_ccitt_byte(input logic [15:0] crc, input logic [7:0] b);
      logic [15:0] c;
      c = crc;
      for (int i = 7; i >= 0; i--) begin
         if (c[15] ^ b[i]) c = {c[14:0], 1'b0} ^ CRC_CCITT_POLY;
         else              c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

   // Data cells sit on even raw positions; clock cells on odd ones are dropped.
   function automatic logic [7:0] mfm_data_bits(input logic [15:0] raw);
      logic [7:0] d;
      for (int i = 0; i < 8; i++) d[i] = raw[2*i];
      return d;
   endfunction

endpackage

// File: rtl/mfm_cell_framer.sv
// Turns separator SHAPED_DATA/DWIN into MFM bit-cells: each DWIN transition
// closes a cell whose bit is 1 if any pulse was seen during it.
module mfm_cell_framer (
   input  logic        u2b_clk,
   input  logic        u2a_nPreset,
   input  logic        shaped_data,
   input  logic        dwin,
   output logic        cell_valid,
   output logic        cell_bit,
   output logic [15:0] raw
);

   logic dwin_q;
   logic pulse_latch;

   assign cell_valid = dwin ^ dwin_q;
   // A pulse on the closing cycle belongs to the cell being closed.
   assign cell_bit   = pulse_latch | shaped_data;

   always_ff @(posedge u2b_clk or negedge u2a_nPreset) begin
      if (!u2a_nPreset) begin
         dwin_q      <= 1'b0;
         pulse_latch <= 1'b0;
         raw         <= '0;
      end else begin
         dwin_q <= dwin;
         if (cell_valid) begin
            raw         <= {raw[14:0], cell_bit};
            pulse_latch <= 1'b0;
         end else if (shaped_data) begin
            pulse_latch <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/flux_acq_sequencer.sv
// MFM capture sequencer: sync hunt, byte deserialisation and FIFO writes.
// Define MFM_CRC_EN to generate the running CRC-16/CCITT on crc_value.
module flux_acq_sequencer
   import flux_pkg::*;
#(
   parameter logic [15:0] SYNC_WORD = MFM_SYNC_A1,
   parameter logic [7:0]  SYNC_BYTE = MFM_SYNC_BYTE,
   parameter int          COUNT_W   = 16
) (
   input  logic               u2b_clk,
   input  logic               u2a_nPreset,
   input  logic               start,
   input  logic               abort,
   input  logic               wait_index,
   input  logic               index,
   input  logic [COUNT_W-1:0] byte_limit,
   input  logic               shaped_data,
   input  logic               dwin,
   input  logic               fifo_full,
   output logic               fifo_wr,
   output logic [7:0]         fifo_data,
   output logic               busy,
   output logic               done,
   output logic               sync_found,
   output logic               overflow,
   output logic [15:0]        crc_value
);

   seq_state_e         state, state_nxt;
   logic               cell_valid, cell_bit;
   logic [15:0]        raw, raw_upd;
   logic               index_q, idx_edge, limit_zero;
   logic [3:0]         cell_cnt;
   logic [COUNT_W-1:0] byte_cnt, cnt_inc;
   logic [7:0]         byte_q;
   logic               wr_pend;
   logic               sync_hit, sync_enter, byte_done, idx_stop;
   logic               wr_cycle, limit_hit, arm;

   mfm_cell_framer u_framer (
      .u2b_clk     (u2b_clk),
      .u2a_nPreset (u2a_nPreset),
      .shaped_data (shaped_data),
      .dwin        (dwin),
      .cell_valid  (cell_valid),
      .cell_bit    (cell_bit),
      .raw         (raw)
   );

   assign raw_upd    = {raw[14:0], cell_bit};
   assign idx_edge   = index & ~index_q;
   assign limit_zero = (byte_limit == '0);

   // The decoded comparison also rejects an inconsistent SYNC_WORD/SYNC_BYTE pair.
   assign sync_hit  = (state == HUNT) && cell_valid && (raw_upd == SYNC_WORD) &&
                      (mfm_data_bits(raw_upd) == SYNC_BYTE);
   assign byte_done = (state == CAPTURE) && cell_valid && (cell_cnt == 4'd15);
   assign idx_stop  = (state == CAPTURE) && limit_zero && idx_edge;

   // The write cycle counts the byte even when the FIFO is full; abort and
   // an index stop discard it entirely.
   assign wr_cycle  = wr_pend && !abort && !idx_stop;
   assign fifo_wr   = wr_cycle && !fifo_full;
   assign cnt_inc   = (byte_cnt == '1) ? byte_cnt : byte_cnt + 1'b1;
   assign limit_hit = wr_cycle && !limit_zero && (cnt_inc == byte_limit);

   assign arm        = ((state == IDLE) || (state == DONE)) && start && !abort;
   assign sync_enter = (state == HUNT) && (state_nxt == CAPTURE);

   assign busy = (state == WAIT_INDEX) || (state == HUNT) || (state == CAPTURE);
   assign done = (state == DONE);

   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE, DONE: if (start) state_nxt = wait_index ? WAIT_INDEX : HUNT;
            WAIT_INDEX: if (idx_edge) state_nxt = HUNT;
            HUNT: begin
               if (limit_zero && idx_edge) state_nxt = DONE;
               else if (sync_hit)          state_nxt = CAPTURE;
            end
            CAPTURE:    if (idx_stop || limit_hit) state_nxt = DONE;
            default:    state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge u2b_clk or negedge u2a_nPreset) begin
      if (!u2a_nPreset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge u2b_clk or negedge u2a_nPreset) begin
      if (!u2a_nPreset) begin
         index_q    <= 1'b0;
         cell_cnt   <= '0;
         byte_cnt   <= '0;
         byte_q     <= '0;
         wr_pend    <= 1'b0;
         sync_found <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         index_q <= index;
         wr_pend <= byte_done && (state_nxt == CAPTURE);
         if (byte_done) byte_q <= mfm_data_bits(raw_upd);

         if (sync_enter)                          cell_cnt <= '0;
         else if ((state == CAPTURE) && cell_valid) cell_cnt <= cell_cnt + 1'b1;

         if (arm) begin
            sync_found <= 1'b0;
            overflow   <= 1'b0;
            byte_cnt   <= '0;
         end else begin
            if (sync_enter) sync_found <= 1'b1;
            if (wr_cycle) begin
               byte_cnt <= cnt_inc;
               if (fifo_full) overflow <= 1'b1;
            end
         end
      end
   end

   assign fifo_data = byte_q;

`ifdef MFM_CRC_EN
   logic [15:0] crc_q;

   always_ff @(posedge u2b_clk or negedge u2a_nPreset) begin
      if (!u2a_nPreset) begin
         crc_q <= '0;
      end else if (sync_enter) begin
         crc_q <= crc_ccitt_byte(CRC_INIT, SYNC_BYTE);
      end else if (wr_cycle) begin
         crc_q <= crc_ccitt_byte(crc_q, byte_q);
      end
   end

   assign crc_value = crc_q;
`else
   assign crc_value = '0;
`endif

endmodule

// File: tb/tb_flux_acq_sequencer.sv
// Directed bench for flux_acq_sequencer: table of capture scenarios plus
// hand sequences for abort, reset, and coincident-pulse corners.
module tb_flux_acq_sequencer;

   logic        u2b_clk = 1'b0;
   logic        u2a_nPreset;
   logic        start, abort, wait_index, index;
   logic [15:0] byte_limit;
   logic        shaped_data, dwin, fifo_full;
   logic        fifo_wr;
   logic [7:0]  fifo_data;
   logic        busy, done, sync_found, overflow;
   logic [15:0] crc_value;

   int total = 0;
   int bad   = 0;
   logic [7:0] wr_q[$];
   bit last_d;

   flux_acq_sequencer dut (
      .u2b_clk     (u2b_clk),
      .u2a_nPreset (u2a_nPreset),
      .start       (start),
      .abort       (abort),
      .wait_index  (wait_index),
      .index       (index),
      .byte_limit  (byte_limit),
      .shaped_data (shaped_data),
      .dwin        (dwin),
      .fifo_full   (fifo_full),
      .fifo_wr     (fifo_wr),
      .fifo_data   (fifo_data),
      .busy        (busy),
      .done        (done),
      .sync_found  (sync_found),
      .overflow    (overflow),
      .crc_value   (crc_value)
   );

   always #5 u2b_clk = ~u2b_clk;

   always @(negedge u2b_clk) if (fifo_wr === 1'b1) wr_q.push_back(fifo_data);

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge u2b_clk);
      #2;
   endtask

   function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[15] != b[7-i]) r = (r << 1) ^ 16'h1021;
         else                 r = r << 1;
      end
      return r;
   endfunction

   // MFM encode one byte given the previous data bit; returns 16 cells MSB first.
   function automatic logic [15:0] mfm_enc(input logic [7:0] b, input bit prev);
      logic [15:0] w;
      bit p;
      p = prev;
      for (int i = 7; i >= 0; i--) begin
         w[2*i+1] = ~(p | b[i]);
         w[2*i]   = b[i];
         p        = b[i];
      end
      return w;
   endfunction

   // One cell = two cycles; pulse either mid-cell or on the closing cycle.
   task automatic send_cell(input bit b, input bit coin, input bit ff);
      tick();
      fifo_full = ff;
      shaped_data = coin ? 1'b0 : b;
      tick();
      shaped_data = coin ? b : 1'b0;
      dwin = ~dwin;
   endtask

   task automatic send_cells(input logic [15:0] w, input int n, input bit coin, input bit ff);
      for (int i = 15; i > 15 - n; i--) send_cell(w[i], coin, ff);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit coin, input bit ff);
      send_cells(mfm_enc(b, last_d), 16, coin, ff);
      last_d = b[0];
   endtask

   task automatic send_sync(input bit coin);
      send_byte(8'h00, coin, 1'b0);
      send_byte(8'h00, coin, 1'b0);
      send_cells(16'h4489, 16, coin, 1'b0);
      last_d = 1'b1;
   endtask

   task automatic flush(input bit ff);
      tick();
      fifo_full = ff;
      shaped_data = 1'b0;
      tick();
      fifo_full = 1'b0;
      tick();
   endtask

   task automatic do_start(input bit wi, input logic [15:0] lim);
      tick();
      start = 1'b1;
      wait_index = wi;
      byte_limit = lim;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_index();
      tick();
      index = 1'b1;
      tick();
      index = 1'b0;
      tick();
   endtask

   task automatic do_abort();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   typedef struct packed {
      bit              wait_idx;
      logic [15:0]     limit;
      int              nbytes;
      logic [9:0][7:0] data;
      logic [9:0]      full_mask;
      int              exp_nwr;
      logic            exp_ovf;
      logic [15:0]     exp_crc;
   } vec_t;

   vec_t vecs[4];

   initial begin
      logic [15:0] c;
      logic [7:0]  crc_bytes[10];
      logic [7:0]  exp_b;
      int          k;

      u2a_nPreset = 1'b0;
      start = 0; abort = 0; wait_index = 0; index = 0; byte_limit = '0;
      shaped_data = 0; dwin = 0; fifo_full = 0;
      last_d = 1'b0;

      // Scenario table: unlimited+index, limit with index gate, FIFO full, CRC frame.
      vecs[0] = '0;
      vecs[0].limit = 16'd0; vecs[0].nbytes = 2;
      vecs[0].data[0] = 8'h5A; vecs[0].data[1] = 8'h00;
      vecs[0].exp_nwr = 2; vecs[0].exp_ovf = 1'b0;

      vecs[1] = '0;
      vecs[1].wait_idx = 1'b1; vecs[1].limit = 16'd2; vecs[1].nbytes = 3;
      vecs[1].data[0] = 8'h3C; vecs[1].data[1] = 8'hFF; vecs[1].data[2] = 8'h81;
      vecs[1].exp_nwr = 2; vecs[1].exp_ovf = 1'b0;

      vecs[2] = '0;
      vecs[2].limit = 16'd3; vecs[2].nbytes = 3;
      vecs[2].data[0] = 8'h11; vecs[2].data[1] = 8'h22; vecs[2].data[2] = 8'hC3;
      vecs[2].full_mask = 10'b0000000010;
      vecs[2].exp_nwr = 2; vecs[2].exp_ovf = 1'b1;

      crc_bytes[0] = 8'hA1; crc_bytes[1] = 8'hA1; crc_bytes[2] = 8'hA1; crc_bytes[3] = 8'hFE;
      crc_bytes[4] = 8'h00; crc_bytes[5] = 8'h00; crc_bytes[6] = 8'h01; crc_bytes[7] = 8'h02;
      c = 16'hFFFF;
      for (int i = 0; i < 8; i++) c = crc_ref(c, crc_bytes[i]);
      crc_bytes[8] = c[15:8];
      crc_bytes[9] = c[7:0];
      vecs[3] = '0;
      vecs[3].limit = 16'd9; vecs[3].nbytes = 9;
      for (int i = 0; i < 9; i++) vecs[3].data[i] = crc_bytes[i+1];
      vecs[3].exp_nwr = 9; vecs[3].exp_ovf = 1'b0;
      vecs[3].exp_crc = 16'h0000;

      // Reset state
      tick(); tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_fifo_wr", fifo_wr, 0);
      chk("rst_fifo_data", fifo_data, 0);
      chk("rst_sync", sync_found, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_crc", crc_value, 0);
      u2a_nPreset = 1'b1;
      tick();

      for (int v = 0; v < 4; v++) begin
         do_start(vecs[v].wait_idx, vecs[v].limit);
         chk($sformatf("v%0d_busy_armed", v), busy, 1);
         chk($sformatf("v%0d_sync_cleared", v), sync_found, 0);
         wr_q.delete();
         if (vecs[v].wait_idx) begin
            send_sync(1'b0);
            tick();
            chk($sformatf("v%0d_presync_ignored", v), sync_found, 0);
            chk($sformatf("v%0d_wait_busy", v), busy, 1);
            pulse_index();
         end
         send_sync(1'b0);
         tick();
         chk($sformatf("v%0d_sync", v), sync_found, 1);
         for (int i = 0; i < vecs[v].nbytes; i++)
            send_byte(vecs[v].data[i], 1'b0, (i > 0) ? vecs[v].full_mask[i-1] : 1'b0);
         flush(vecs[v].full_mask[vecs[v].nbytes-1]);
         if (vecs[v].limit == 0) begin
            chk($sformatf("v%0d_busy_before_index", v), busy, 1);
            pulse_index();
         end
         chk($sformatf("v%0d_done", v), done, 1);
         chk($sformatf("v%0d_busy_off", v), busy, 0);
         chk($sformatf("v%0d_ovf", v), overflow, vecs[v].exp_ovf);
         chk($sformatf("v%0d_nwr", v), wr_q.size(), vecs[v].exp_nwr);
         k = 0;
         for (int i = 0; i < vecs[v].nbytes; i++) begin
            if (vecs[v].limit != 0 && i >= vecs[v].limit) break;
            if (vecs[v].full_mask[i]) continue;
            exp_b = vecs[v].data[i];
            if (k < wr_q.size()) chk($sformatf("v%0d_byte%0d", v, i), wr_q[k], exp_b);
            k++;
         end
         if (v == 3) chk("v3_crc_residue", crc_value, vecs[v].exp_crc);
      end

      // Abort at cell 9 of a byte: no write, IDLE next cycle, flags kept.
      do_start(1'b0, 16'd0);
      wr_q.delete();
      send_sync(1'b0);
      send_cells(mfm_enc(8'h5A, last_d), 9, 1'b0, 1'b0);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_idle_busy", busy, 0);
      chk("abort_idle_done", done, 0);
      chk("abort_sync_kept", sync_found, 1);
      flush(1'b0);
      chk("abort_nwr", wr_q.size(), 0);
      do_start(1'b0, 16'd0);
      chk("restart_sync_clr", sync_found, 0);
      do_abort();

      // Abort on the write cycle suppresses the pending write.
      do_start(1'b0, 16'd0);
      wr_q.delete();
      send_sync(1'b0);
      send_byte(8'h5A, 1'b0, 1'b0);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
      chk("abort_wr_nwr", wr_q.size(), 0);
      chk("abort_wr_busy", busy, 0);

      // Reset asserted on the write cycle drops the write and returns to IDLE.
      do_start(1'b0, 16'd0);
      wr_q.delete();
      send_sync(1'b0);
      send_byte(8'h77, 1'b0, 1'b0);
      tick();
      u2a_nPreset = 1'b0;
      tick();
      chk("rstmid_nwr", wr_q.size(), 0);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_sync", sync_found, 0);
      u2a_nPreset = 1'b1;
      dwin = 1'b0;
      tick();

      // Pulses coincident with the closing DWIN edge.
      do_start(1'b0, 16'd0);
      wr_q.delete();
      last_d = 1'b0;
      send_sync(1'b1);
      tick();
      chk("coin_sync", sync_found, 1);
`ifdef MFM_CRC_EN
      chk("coin_crc_init", crc_value, crc_ref(16'hFFFF, 8'hA1));
`else
      chk("coin_crc_init", crc_value, 16'h0000);
`endif
      send_byte(8'h5A, 1'b1, 1'b0);
      flush(1'b0);
      chk("coin_nwr", wr_q.size(), 1);
      if (wr_q.size() > 0) chk("coin_byte", wr_q[0], 8'h5A);
      pulse_index();
      chk("coin_done", done, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/flux_acq_sequencer.md
Name: flux_acq_sequencer

Overview:
Capture sequencer that sits downstream of the PJL data separator. It consumes the separator's SHAPED_DATA and DWIN outputs and turns them into raw MFM bit-cells. It then hunts for a sync word, deserialises data bytes and writes them to the acquisition FIFO. Host control is a start/abort pair, with an optional index-pulse gate and a byte-count limit.

Parameters:
- SYNC_WORD, 16'h4489: raw MFM cell pattern to hunt for (A1 with missing clock).
- SYNC_BYTE, 8'hA1: decoded value of SYNC_WORD; folded into the CRC at sync detect.
- COUNT_W, 16: width of the byte-count limit and counter.

Ports:
- u2b_clk  in  1  sequencer clock; same edge as the separator's sampling clock.
- u2a_nPreset  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse; arms a capture (ignored unless IDLE or DONE).
- abort  in  1  one-cycle pulse; returns to IDLE from any state.
- wait_index  in  1  sampled at start; 1 means wait for an index rising edge before hunting.
- index  in  1  drive index pulse, already synchronised, active-high.
- byte_limit  in  COUNT_W  bytes to capture after sync; 0 means unlimited (stop on index or abort).
- shaped_data  in  1  separator SHAPED_DATA.
- dwin  in  1  separator DWIN.
- fifo_full  in  1  FIFO full flag.
- fifo_wr  out  1  one-cycle write strobe.
- fifo_data  out  8  decoded data byte.
- busy  out  1  high in WAIT_INDEX, HUNT and CAPTURE.
- done  out  1  high in DONE.
- sync_found  out  1  sticky; set at sync detect, cleared at start.
- overflow  out  1  sticky; set when a byte is dropped, cleared at start.
- crc_value  out  16  running CRC (see Optional Feature).

Behaviour:
- Reset: state IDLE; all outputs 0; shift register, counters and latches 0; dwin_q captured as 0.
- Cell framing:
  - dwin is registered as dwin_q. Any transition (dwin != dwin_q) closes the current bit-cell.
  - pulse_latch sets on any cycle with shaped_data=1.
  - On the closing cycle the cell bit = pulse_latch | shaped_data, shifted into the LSB of a 16-bit raw register. pulse_latch then clears.
  - A pulse coincident with the closing edge belongs to the closing cell.
- States and transitions:
  - IDLE: on start, go to WAIT_INDEX if wait_index=1, else HUNT. Clear sync_found, overflow and the byte counter.
  - WAIT_INDEX: on index rising edge (index & !index_q), go to HUNT.
  - HUNT: on the cell-close cycle where the updated raw register == SYNC_WORD:
    - set sync_found, reset cell counter to 0, initialise CRC, go to CAPTURE;
    - if byte_limit=0 and an index edge arrives, go to DONE.
  - CAPTURE:
    - every 16 cells form one byte: data bits are raw bits 14,12,...,0 (MSB first); clock bits are discarded;
    - on the 16th cell, drive fifo_data and pulse fifo_wr the following cycle (latency 1 u2b_clk after the cell close);
    - if fifo_full=1 on that cycle: fifo_wr stays 0, the byte is dropped, overflow sets, and the byte counter still advances;
    - when the counter reaches byte_limit (nonzero), go to DONE after the write cycle;
    - when byte_limit=0, an index rising edge goes to DONE; a byte in flight is discarded.
    - further sync words inside CAPTURE are data; there is no re-alignment.
  - DONE: holds outputs. start re-arms; abort goes to IDLE.
- abort has priority over every other transition. It suppresses a pending fifo_wr and leaves the sticky flags intact.
- start while busy is ignored.
- The byte counter saturates at its maximum and never wraps.
- Asserting reset mid-capture forces IDLE immediately; a pending write is lost.

Optional Feature:
- MFM_CRC_EN defined:
  - CRC-16/CCITT (poly 0x1021, MSB first) is computed byte-serially.
  - At sync detect, crc = CRC(0xFFFF, SYNC_BYTE).
  - Every byte captured is folded in, dropped bytes included.
  - crc_value updates on the cycle of fifo_wr and holds in DONE.
- MFM_CRC_EN undefined: crc_value is constant 0 and no CRC logic is generated.

Decomposition:
- Shared package (flux_pkg) holds:
  - the state enum (IDLE, WAIT_INDEX, HUNT, CAPTURE, DONE);
  - MFM_SYNC_A1 = 16'h4489 and CRC_CCITT_POLY = 16'h1021;
  - the CRC init constant 16'hFFFF.
- One sub-module: mfm_cell_framer. It owns dwin_q, pulse_latch and the raw shift register, and outputs cell_valid, cell_bit and raw[15:0].
- The sequencer FSM, counters and CRC stay in the top module.

Test Plan:
- Unlimited capture ended by index: wait_index=0, byte_limit=0; cells for 4489 then MFM for 0x5A 0x00; index edge → fifo_data 5A then 00, sync_found=1, done=1 after the index.
- Byte limit with index gate: wait_index=1; sync before index ignored; index edge, then sync + 3 bytes, byte_limit=2 → exactly 2 writes, then DONE.
- FIFO full: fifo_full held for byte 2 of 3 → writes for bytes 1 and 3 only; overflow=1; DONE after 3 counted bytes.
- Abort mid-byte: abort at cell 9 of a byte → no fifo_wr, IDLE next cycle, sync_found still 1; a later start clears it.
- Coincident pulse: shaped_data high on the same cycle as the dwin toggle → bit counted in the closing cell; next cell reads 0 without a new pulse.
- MFM_CRC_EN: sync + A1 A1 FE 00 00 01 02 followed by correct CRC bytes (10 bytes, limit 9 after sync) → crc_value 16'h0000 in DONE.
